// File: rtl/note_sequencer.sv
// Song player: walks a song ROM and drives a tone generator's note/strobe/mute interface.
// Each ROM word is {note[8:0], dur[6:0]}; dur 0 ends the song, note 9'h1FF is a rest.
module note_sequencer #(
    parameter int TICK_DIV      = 6_250_000,
    parameter int DEPTH         = 256,
    parameter int ADDR_W        = 8,
    parameter int STROBE_CYCLES = 4,
    parameter int GAP_CYCLES    = 1_000_000,
    // Song image: entry i lives at bits [16*i +: 16]
    parameter logic [DEPTH*16-1:0] SONG_INIT = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop,
    output logic [8:0]        o_Note,
    output logic              o_NextNote,
    output logic              o_Mute,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_addr
);

    localparam int CNT_W = $clog2(127 * TICK_DIV + 1);
    localparam int CMP_W = CNT_W + 32;
    localparam logic [CNT_W-1:0] TICK_C = CNT_W'(TICK_DIV);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  fetch_addr_reg, fetch_addr_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [8:0]         note_reg, note_next;
    logic               rest_reg, rest_next;
    logic [CNT_W-1:0]   slot_cnt_reg, slot_cnt_next;
    logic [CNT_W-1:0]   slot_len_reg, slot_len_next;
    logic               mute_reg, mute_next;
    logic               strobe_reg, strobe_next;
    logic               busy_reg;
    logic               done_reg, done_next;
    logic               start_slot, end_song;

    logic [15:0]        rom [DEPTH];
    logic [15:0]        rom_word_reg;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_rom
            assign rom[gi] = SONG_INIT[16*gi +: 16];
        end
    endgenerate

    // One read in FETCH, and one prefetch of the following entry on the first cycle of each slot
    assign rd_en   = (state_reg == FETCH) || (state_reg == PLAY && slot_cnt_reg == '0);
    assign rd_addr = (state_reg == FETCH) ? fetch_addr_reg : addr_reg + ADDR_W'(1);

    always_ff @(posedge i_clk) begin
        if (rd_en) begin
            rom_word_reg <= rom[rd_addr];
        end
    end

    logic [8:0] word_note;
    logic [6:0] word_dur;
    logic       word_marker, word_rest, slot_last, addr_last, gap_hit;

    assign word_note   = rom_word_reg[15:7];
    assign word_dur    = rom_word_reg[6:0];
    assign word_marker = (word_dur == 7'd0);
    assign word_rest   = (word_note == 9'h1FF);
    assign slot_last   = (slot_cnt_reg == slot_len_reg - CNT_W'(1));
    assign addr_last   = (addr_reg == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_next      = state_reg;
        fetch_addr_next = fetch_addr_reg;
        addr_next       = addr_reg;
        note_next       = note_reg;
        rest_next       = rest_reg;
        slot_cnt_next   = slot_cnt_reg;
        slot_len_next   = slot_len_reg;
        done_next       = 1'b0;
        start_slot      = 1'b0;
        end_song        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_start && !i_stop) begin
                    state_next      = FETCH;
                    fetch_addr_next = '0;
                end
            end
            FETCH: state_next = LOAD;
            LOAD: begin
                if (word_marker) end_song = 1'b1;
                else             start_slot = 1'b1;
            end
            PLAY: begin
                if (slot_last) begin
                    if (word_marker || addr_last) end_song = 1'b1;
                    else                          start_slot = 1'b1;
                end else begin
                    slot_cnt_next = slot_cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        if (start_slot) begin
            state_next    = PLAY;
            slot_cnt_next = '0;
            slot_len_next = CNT_W'(word_dur) * TICK_C;
            rest_next     = word_rest;
            addr_next     = (state_reg == LOAD) ? fetch_addr_reg : addr_reg + ADDR_W'(1);
            if (!word_rest) note_next = word_note;
        end

        // A marker at address 0 would loop on nothing, so it always ends the song
        if (end_song) begin
            if (i_loop && !(state_reg == LOAD && fetch_addr_reg == '0)) begin
                state_next      = FETCH;
                fetch_addr_next = '0;
            end else begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
        end

        if (i_stop && state_reg != IDLE) begin
            state_next = IDLE;
            done_next  = 1'b1;
        end

        gap_hit     = (CMP_W'(slot_cnt_next) + CMP_W'(GAP_CYCLES)) >= CMP_W'(slot_len_next);
        mute_next   = (state_next != PLAY) || rest_next || gap_hit;
        strobe_next = (state_next == PLAY) && !rest_next &&
                      (CMP_W'(slot_cnt_next) < CMP_W'(STROBE_CYCLES));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg      <= IDLE;
            fetch_addr_reg <= '0;
            addr_reg       <= '0;
            note_reg       <= '0;
            rest_reg       <= 1'b0;
            slot_cnt_reg   <= '0;
            slot_len_reg   <= '0;
            mute_reg       <= 1'b1;
            strobe_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fetch_addr_reg <= fetch_addr_next;
            addr_reg       <= addr_next;
            note_reg       <= note_next;
            rest_reg       <= rest_next;
            slot_cnt_reg   <= slot_cnt_next;
            slot_len_reg   <= slot_len_next;
            mute_reg       <= mute_next;
            strobe_reg     <= strobe_next;
            busy_reg       <= (state_next != IDLE);
            done_reg       <= done_next;
        end
    end

    // The upcoming note is shown one cycle ahead of its strobe, so the generator sees it settled
    assign o_Note     = note_next;
    assign o_NextNote = strobe_reg;
    assign o_Mute     = mute_reg;
    assign o_busy     = busy_reg;
    assign o_done     = done_reg;
    assign o_addr     = addr_reg;

endmodule
